uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_maj3.sv | 9 +
 rtl/uart_rx_sampler.sv | 117 +++++++++++
 tb/tb_uart_rx_sampler.sv | 119 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver/transmitter shared state encoding and default frame constants
package uart_pkg;
  localparam int UART_PRESCALE  = 8;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_maj3.sv
// uart_maj3: two-out-of-three majority vote over line samples
module uart_maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampled UART bit recovery with start validation and per-bit strobes
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE  = UART_PRESCALE,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_raw,
  input  logic par_en,
  output logic frame_busy,
  output logic rx_bit,
  output logic bit_strobe,
  output logic start_glitch,
  output logic frame_done
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] C_S0  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] C_V   = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(PRESCALE - 1);
  localparam logic [3:0]    NB    = 4'(DATA_BITS);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic sync1_q, rx_s_q, prev_q;
  logic par_q, par_d, s0_q, s0_d, s1_q, s1_d;
  logic busy_q, busy_d, rx_bit_q, rx_bit_d, strobe_q, strobe_d;
  logic glitch_q, glitch_d, done_q, done_d;
  logic vote, at_v, wrap;
  uart_maj3 u_maj3 (.a(s0_q), .b(s1_q), .c(rx_s_q), .y(vote));
  assign at_v = cnt_q == C_V;
  assign wrap = cnt_q == C_END;
  // prev_q resets low so the line must be seen high once before a falling edge counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      par_q    <= 1'b0;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      busy_q   <= 1'b0;
      rx_bit_q <= 1'b0;
      strobe_q <= 1'b0;
      glitch_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= rx_raw;
      rx_s_q   <= sync1_q;
      prev_q   <= rx_s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      par_q    <= par_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      busy_q   <= busy_d;
      rx_bit_q <= rx_bit_d;
      strobe_q <= strobe_d;
      glitch_q <= glitch_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
    bcnt_d   = bcnt_q;
    par_d    = par_q;
    s0_d     = (cnt_q == C_S0) ? rx_s_q : s0_q;
    s1_d     = (cnt_q == C_S1) ? rx_s_q : s1_q;
    busy_d   = busy_q & ~done_q;
    rx_bit_d = rx_bit_q;
    strobe_d = 1'b0;
    glitch_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: if (prev_q && !rx_s_q) begin
        state_d = START;
        par_d   = par_en;
      end
      START: if (at_v) begin
        state_d  = vote ? IDLE : START;
        glitch_d = vote;
        busy_d   = ~vote;
      end else if (wrap) state_d = DATA;
      DATA: if (at_v) begin
        strobe_d = 1'b1;
        rx_bit_d = vote;
        bcnt_d   = bcnt_q + 4'd1;
      end else if (wrap && bcnt_q == NB) begin
        bcnt_d  = '0;
        state_d = par_q ? PARITY : STOP;
      end
      PARITY: if (at_v) begin
        strobe_d = 1'b1;
        rx_bit_d = vote;
      end else if (wrap) state_d = STOP;
      STOP: if (at_v) begin
        strobe_d = 1'b1;
        rx_bit_d = vote;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign frame_busy   = busy_q;
  assign rx_bit       = rx_bit_q;
  assign bit_strobe   = strobe_q;
  assign start_glitch = glitch_q;
  assign frame_done   = done_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for directed UART frames, glitches and reset
module tb_uart_rx_sampler;
  localparam int P = 8;
  logic clk = 1'b0, rst = 1'b0, rx_raw = 1'b1, par_en = 1'b0;
  logic frame_busy, rx_bit, bit_strobe, start_glitch, frame_done;
  int checks = 0, failures = 0, glitches = 0, dones = 0, exp_dones = 0;
  typedef struct packed {logic b; logic d;} exp_t;
  exp_t q[$];
  uart_rx_sampler #(.PRESCALE(P), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx_raw(rx_raw), .par_en(par_en),
    .frame_busy(frame_busy), .rx_bit(rx_bit), .bit_strobe(bit_strobe),
    .start_glitch(start_glitch), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst) begin
    exp_t e;
    if (start_glitch) glitches++;
    if (frame_done) begin
      dones++;
      chk("done_with_strobe", bit_strobe, 1);
    end
    if (bit_strobe) begin
      if (q.size() == 0) chk("unexpected_strobe_queue", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("rx_bit", rx_bit, e.b);
        chk("frame_done", frame_done, e.d);
        chk("busy_at_strobe", frame_busy, 1);
      end
    end
  end
  task automatic drive(input logic b, input int n);
    rx_raw = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pe, input int gbit);
    par_en = pe;
    for (int i = 0; i < 8; i++) q.push_back('{b: d[i], d: 1'b0});
    if (pe) q.push_back('{b: ^d, d: 1'b0});
    q.push_back('{b: 1'b1, d: 1'b1});
    exp_dones++;
    drive(1'b0, P);
    par_en = ~pe;
    for (int i = 0; i < 8; i++)
      if (i == gbit) begin
        drive(d[i], 5);
        drive(~d[i], 1);
        drive(d[i], 2);
      end else drive(d[i], P);
    if (pe) drive(^d, P);
    drive(1'b1, P);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_busy"}, frame_busy, 0);
    chk({name, "_rx_bit"}, rx_bit, 0);
    chk({name, "_strobe"}, bit_strobe, 0);
    chk({name, "_glitch"}, start_glitch, 0);
    chk({name, "_done"}, frame_done, 0);
  endtask
  initial begin
    int g0, d0, busy_hi;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    drive(1'b1, 4);
    send_frame(8'hA5, 1'b1, -1);
    drive(1'b1, 4);
    send_frame(8'h3C, 1'b0, -1);
    drive(1'b1, 4);
    g0 = glitches;
    busy_hi = 0;
    drive(1'b0, 2);
    rx_raw = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (frame_busy) busy_hi++;
      @(negedge clk);
    end
    chk("glitch_count", glitches - g0, 1);
    chk("glitch_busy", busy_hi, 0);
    send_frame(8'h5A, 1'b1, 2);
    drive(1'b1, 4);
    send_frame(8'h81, 1'b0, 7);
    drive(1'b1, 4);
    d0 = dones;
    send_frame(8'h00, 1'b0, -1);
    send_frame(8'hFF, 1'b1, -1);
    drive(1'b1, 4);
    chk("b2b_done", dones - d0, 2);
    v = 8'h96;
    par_en = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back('{b: v[i], d: 1'b0});
    drive(1'b0, P);
    for (int i = 0; i < 4; i++) drive(v[i], P);
    drive(v[4], 3);
    #2 rst = 1'b0;
    #1 chk_zero("rst_mid");
    rx_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4);
    chk("rst_queue", q.size(), 0);
    d0 = dones;
    send_frame(8'hC3, 1'b1, -1);
    drive(1'b1, 20);
    chk("post_rst_done", dones - d0, 1);
    chk("queue_empty", q.size(), 0);
    chk("done_total", dones, exp_dones);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
